conv_sched: RTL and testbench

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_pkg.sv | 31 +++
 rtl/conv_sched_if.sv | 30 +++
 rtl/conv_mac.sv | 30 +++
 rtl/conv_sched.sv | 136 +++++++++++++
 tb/tb_conv_sched.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the convolution scheduler: default sizes, index width,
// FSM state encoding and the per-k product index bounds.
package conv_pkg;

    localparam int N_DEF  = 21;
    localparam int DW_DEF = 21;
    localparam int RW_DEF = 2 * DW_DEF + 5;
    localparam int IW     = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_MAC  = 2'd2;
    localparam state_t ST_OUT  = 2'd3;

    // First product index for output k: max(0, k-n+1)
    function automatic logic [IW-1:0] lo_idx(input logic [IW-1:0] k, input int n);
        logic [IW-1:0] nm1;
        nm1 = IW'(n - 1);
        return (k > nm1) ? (k - nm1) : '0;
    endfunction

    // Last product index for output k: min(k, n-1)
    function automatic logic [IW-1:0] hi_idx(input logic [IW-1:0] k, input int n);
        logic [IW-1:0] nm1;
        nm1 = IW'(n - 1);
        return (k < nm1) ? k : nm1;
    endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Control, sample-input and result-output signals of the convolution scheduler.
interface conv_sched_if #(
    parameter int DW = 21,
    parameter int RW = 47
);
    import conv_pkg::*;

    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          busy;
    logic          done;

    modport slave (
        input  start, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, busy, done
    );

    modport master (
        output start, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, busy, done
    );

endinterface

// File: rtl/conv_mac.sv
// Unsigned DW x DW multiplier feeding an RW-bit accumulator with clear and enable.
module conv_mac #(
    parameter int DW = 21,
    parameter int RW = 47
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] acc
);

    logic [2*DW-1:0] prod;

    assign prod = a * b;

    // NOTE: clear outranks enable so an abort in the middle of a sum never leaks a partial product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + RW'(prod);
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Loads two N-sample signals, then computes and streams their full linear
// convolution one output at a time, one multiply-accumulate per cycle.
module conv_sched
    import conv_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input logic         clk,
    input logic         rst,
    conv_sched_if.slave bus
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(2 * N + 1);
    localparam logic [IW-1:0] K_LAST = IW'(2 * N - 2);

    state_t        state;
    logic [LW-1:0] ld_cnt;
    logic [LW-1:0] ld_b;
    logic [IW-1:0] k;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic          done_q;
    logic          xfer;
    logic          load_last;
    logic          accept;
    logic          mac_clr;
    logic          mac_en;
    logic [RW-1:0] acc;

    logic [DW-1:0] buf_a [N];
    logic [DW-1:0] buf_b [N];

    assign xfer      = (state == ST_LOAD) && bus.in_valid;
    assign load_last = (ld_cnt == LW'(2 * N - 1));
    assign accept    = (state == ST_OUT) && bus.out_ready;
    assign ld_b      = ld_cnt - LW'(N);
    assign j         = k - i;

    // NOTE: sample buffers carry no reset; every job rewrites all entries before they are read.
    always_ff @(posedge clk) begin
        if (xfer && !bus.abort) begin
            if (ld_cnt < LW'(N)) begin
                buf_a[ld_cnt[AW-1:0]] <= bus.in_data;
            end else begin
                buf_b[ld_b[AW-1:0]] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            ld_cnt <= '0;
            k      <= '0;
            i      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state  <= ST_IDLE;
                ld_cnt <= '0;
                k      <= '0;
                i      <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state  <= ST_LOAD;
                            ld_cnt <= '0;
                        end
                    end
                    ST_LOAD: begin
                        if (xfer) begin
                            ld_cnt <= ld_cnt + LW'(1);
                            if (load_last) begin
                                state <= ST_MAC;
                                k     <= '0;
                                i     <= '0;
                            end
                        end
                    end
                    ST_MAC: begin
                        if (i == hi_idx(k, N)) begin
                            state <= ST_OUT;
                        end else begin
                            i <= i + IW'(1);
                        end
                    end
                    ST_OUT: begin
                        if (bus.out_ready) begin
                            if (k == K_LAST) begin
                                state  <= ST_IDLE;
                                k      <= '0;
                                i      <= '0;
                                done_q <= 1'b1;
                            end else begin
                                state <= ST_MAC;
                                k     <= k + IW'(1);
                                i     <= lo_idx(k + IW'(1), N);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Accumulator is held only while summing or presenting; it starts at zero on every MAC entry.
    assign mac_clr = bus.abort || (state == ST_IDLE) || (state == ST_LOAD) || accept;
    assign mac_en  = (state == ST_MAC);

    conv_mac #(
        .DW (DW),
        .RW (RW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (buf_a[i[AW-1:0]]),
        .b   (buf_b[j[AW-1:0]]),
        .acc (acc)
    );

    assign bus.in_ready  = (state == ST_LOAD);
    assign bus.out_valid = (state == ST_OUT);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.out_data  = (state == ST_OUT) ? acc : '0;
    assign bus.out_index = (state == ST_OUT) ? k : '0;

endmodule

// File: tb/tb_conv_sched.sv
// Directed and randomized jobs for conv_sched, checked against a pairwise-sum
// convolution model held in the bench.
module tb_conv_sched;
    import conv_pkg::*;

    localparam int N  = 21;
    localparam int DW = 21;
    localparam int RW = 47;
    localparam int NK = 2 * N - 1;
    // One edge to accept start, 2N loads, N*N products, 2N-1 result handoffs
    localparam int EXP_CYC = 1 + 2 * N + N * N + (2 * N - 1);

    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] sa [N];
    logic [DW-1:0] sb [N];
    logic [63:0]   exp_r [NK];
    logic [63:0]   obs [NK];

    conv_sched_if #(.DW(DW), .RW(RW)) bus ();

    conv_sched #(
        .N  (N),
        .DW (DW),
        .RW (RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},      64'(bus.busy), 64'd0);
        check({tag, " in_ready"},  64'(bus.in_ready), 64'd0);
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " done"},      64'(bus.done), 64'd0);
        check({tag, " out_data"},  64'(bus.out_data), 64'd0);
        check({tag, " out_index"}, 64'(bus.out_index), 64'd0);
    endtask

    // mode 0: all ones, 1: impulse a / ramp b, 2: all max, 3: random
    task automatic fill(input int mode);
        for (int n = 0; n < N; n++) begin
            case (mode)
                0: begin sa[n] = 1; sb[n] = 1; end
                1: begin sa[n] = (n == 0) ? DW'(1) : DW'(0); sb[n] = DW'(n + 1); end
                2: begin sa[n] = '1; sb[n] = '1; end
                default: begin sa[n] = DW'($urandom); sb[n] = DW'($urandom); end
            endcase
        end
        for (int k = 0; k < NK; k++) exp_r[k] = 64'd0;
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
                exp_r[a + b] += 64'(sa[a]) * 64'(sb[b]);
    endtask

    // Runs one job from IDLE. Entered and left at posedge+1.
    task automatic run_job(input int gap, input int stall_k, input int abort_k,
                           input int busy_start, input int rst_at_ld, output int cycles);
        int ld;
        int got;
        int stall;
        bit ended;
        bit do_abort;
        ld = 0; got = 0; stall = 0; ended = 0; cycles = 0;
        for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
            bus.start    = (cyc == 0) || (cyc == busy_start);
            bus.in_valid = 1'b0;
            bus.in_data  = DW'($urandom);
            bus.out_ready = 1'b1;
            do_abort = 1'b0;
            if (bus.in_ready) begin
                if (ld == rst_at_ld) begin
                    rst = 1'b0;
                    #1;
                    check_idle_outputs("rst mid-load");
                    rst = 1'b1;
                    bus.start = 1'b0;
                    @(posedge clk); #1;
                    return;
                end
                if (gap == 0 || $urandom_range(0, 2) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = (ld < N) ? sa[ld] : sb[ld - N];
                    ld++;
                end
            end
            if (stall_k >= 0 && got == stall_k && stall > 0)
                check($sformatf("stall valid %0d", stall), 64'(bus.out_valid), 64'd1);
            if (bus.out_valid) begin
                check($sformatf("index k=%0d", got), 64'(bus.out_index), 64'(got));
                check($sformatf("data k=%0d", got), 64'(bus.out_data), exp_r[got]);
                obs[got] = 64'(bus.out_data);
                if (got == stall_k && stall < 5) begin
                    bus.out_ready = 1'b0;
                    stall++;
                end else begin
                    got++;
                end
            end
            if (abort_k >= 0 && got == abort_k && bus.busy && !bus.in_ready && !bus.out_valid) begin
                bus.abort = 1'b1;
                do_abort  = 1'b1;
            end
            @(posedge clk); #1;
            cycles++;
            if (do_abort) begin
                bus.abort = 1'b0;
                bus.start = 1'b0;
                check_idle_outputs("after abort");
                repeat (4) begin
                    @(posedge clk); #1;
                    check("no done after abort", 64'(bus.done), 64'd0);
                end
                return;
            end
            if (bus.done) begin
                check("done after last accept", 64'(got), 64'(NK));
                ended = 1'b1;
            end
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        check("job finished in budget", 64'(ended), 64'd1);
        repeat (2) begin
            @(posedge clk); #1;
            check("done single pulse", 64'(bus.done), 64'd0);
            check("idle after job", 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        int cyc1;
        int cyc;
        logic [63:0] m;

        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        #1;
        check_idle_outputs("reset");
        #11 rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("out of reset");

        fill(0);
        run_job(0, -1, -1, -1, -1, cyc1);
        check("ones cycle count", 64'(cyc1), 64'(EXP_CYC));

        fill(1);
        run_job(1, -1, -1, -1, -1, cyc);

        fill(2);
        run_job(0, -1, -1, -1, -1, cyc);
        m = (64'd1 << 21) - 64'd1;
        check("max result k=20", obs[20], 64'd21 * m * m);

        fill(3);
        run_job(1, 3, -1, -1, -1, cyc);

        fill(3);
        run_job(0, -1, -1, 100, -1, cyc);
        check("busy start cycle count", 64'(cyc), 64'(cyc1));

        fill(3);
        run_job(0, -1, 10, -1, -1, cyc);
        fill(3);
        run_job(1, -1, -1, -1, -1, cyc);

        fill(3);
        run_job(0, -1, -1, -1, 15, cyc);
        fill(3);
        run_job(0, -1, -1, -1, -1, cyc);
        check("post-reset cycle count", 64'(cyc), 64'(EXP_CYC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
